msdap_ctrl: RTL and testbench

Main sequencing controller for the MSDAP stereo filter core, clocked on SCLK. It consumes deserialized stereo words from the input shifter, routes them as Rj values, coefficients or samples into the respective memories, and triggers the ALU once per sample. It also handles data-memory clearing, soft reset and sleep/wake, and drives InReady to the host.

---
 rtl/msdap_ctrl_if.sv | 41 ++++
 rtl/msdap_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_msdap_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/msdap_ctrl_if.sv
// msdap_ctrl_if: bundle between the MSDAP sequencing controller and its
// surroundings (host control, input shifter, memories and ALU).
//   slave  : the controller side (consumes words, drives memory/ALU strobes)
//   master : the environment side
// Signals:
//   Start, word_valid, word_l, word_r, alu_done    -> controller
//   InReady, rj_we, coef_we, data_we, wr_addr,
//   wdata_l, wdata_r, alu_start, x_head, sleep,
//   overrun                                       <- controller
interface msdap_ctrl_if #(
    parameter int AW = 9
);
    logic          Start;
    logic          word_valid;
    logic [15:0]   word_l;
    logic [15:0]   word_r;
    logic          alu_done;
    logic          InReady;
    logic          rj_we;
    logic          coef_we;
    logic          data_we;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wdata_l;
    logic [15:0]   wdata_r;
    logic          alu_start;
    logic [AW-1:0] x_head;
    logic          sleep;
    logic          overrun;

    modport slave (
        input  Start, word_valid, word_l, word_r, alu_done,
        output InReady, rj_we, coef_we, data_we, wr_addr, wdata_l, wdata_r,
               alu_start, x_head, sleep, overrun
    );

    modport master (
        output Start, word_valid, word_l, word_r, alu_done,
        input  InReady, rj_we, coef_we, data_we, wr_addr, wdata_l, wdata_r,
               alu_start, x_head, sleep, overrun
    );
endinterface

// File: rtl/msdap_ctrl.sv
// msdap_ctrl: main sequencing controller of the MSDAP stereo filter core.
// Routes deserialized stereo words into Rj / coefficient / sample memory,
// clears sample memory, launches the ALU once per sample and handles sleep.
// Ports:
//   SCLK     system clock (rising edge)
//   Reset_n  asynchronous active-low reset (enters CLEAR, keeps load flags)
//   bus      msdap_ctrl_if.slave, see interface header for signal list
// All bus outputs are registered: a word seen at cycle t shows its write
// strobe at t+1 and, for samples, alu_start at t+2.
module msdap_ctrl #(
    parameter int NUM_RJ      = 16,
    parameter int NUM_COEF    = 512,
    parameter int DATA_DEPTH  = 256,
    parameter int SLEEP_COUNT = 800,
    parameter int AW          = 9
) (
    input  logic         SCLK,
    input  logic         Reset_n,
    msdap_ctrl_if.slave  bus
);
    localparam int DW = $clog2(DATA_DEPTH);
    localparam int ZW = $clog2(SLEEP_COUNT + 1);
    localparam logic [AW-1:0] RJ_LAST   = AW'(NUM_RJ - 1);
    localparam logic [AW-1:0] COEF_LAST = AW'(NUM_COEF - 1);
    localparam logic [DW-1:0] CLR_LAST  = DW'(DATA_DEPTH - 1);
    localparam logic [ZW-1:0] ZC_MAX    = ZW'(SLEEP_COUNT);

    typedef enum logic [2:0] {INIT, LOAD_RJ, LOAD_COEF, RUN, SLEEP, CLEAR} state_t;

    state_t        r_state, w_next;
    logic [DW-1:0] r_clr_cnt, r_head, r_pend_addr;
    logic [AW-1:0] r_cnt;
    logic [ZW-1:0] r_zero_cnt, w_zc_inc;
    logic          r_rj_loaded, r_coef_loaded;
    logic          r_alu_busy, r_pend, r_overrun;
    logic          r_inready, r_sleep, r_alu_start;
    logic          r_rj_we, r_coef_we, r_data_we;
    logic [AW-1:0] r_wr_addr, r_x_head;
    logic [15:0]   r_wdata_l, r_wdata_r;

    logic          w_zero, w_clr_last, w_active, w_sample, w_issue;
    logic          w_rj_we, w_coef_we, w_data_we;
    logic [AW-1:0] w_addr;
    logic [15:0]   w_wl, w_wr;

    assign w_zero     = (bus.word_l == '0) && (bus.word_r == '0);
    assign w_clr_last = (r_clr_cnt == CLR_LAST);
    assign w_zc_inc   = (r_zero_cnt == ZC_MAX) ? r_zero_cnt : r_zero_cnt + ZW'(1);
    assign w_active   = (r_state == RUN) || (r_state == SLEEP);

    // State register
    always_ff @(posedge SCLK or negedge Reset_n) begin
        if (!Reset_n) r_state <= CLEAR;
        else          r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            INIT:      if (w_clr_last) w_next = LOAD_RJ;
            CLEAR:     if (w_clr_last) w_next = r_coef_loaded ? RUN :
                                                r_rj_loaded   ? LOAD_COEF : LOAD_RJ;
            LOAD_RJ:   if (bus.word_valid && r_cnt == RJ_LAST)   w_next = LOAD_COEF;
            LOAD_COEF: if (bus.word_valid && r_cnt == COEF_LAST) w_next = RUN;
            RUN:       if (bus.word_valid && w_zero && w_zc_inc == ZC_MAX) w_next = SLEEP;
            SLEEP:     if (bus.word_valid && !w_zero) w_next = RUN;
            default:   w_next = CLEAR;
        endcase
        if (bus.Start) w_next = INIT;
    end

    // Output logic: next values of the registered write port
    always_comb begin
        w_rj_we   = 1'b0;
        w_coef_we = 1'b0;
        w_data_we = 1'b0;
        w_sample  = 1'b0;
        w_addr    = '0;
        w_wl      = '0;
        w_wr      = '0;
        case (r_state)
            INIT, CLEAR: begin
                w_data_we = 1'b1;
                w_addr    = AW'(r_clr_cnt);
            end
            LOAD_RJ: if (bus.word_valid) begin
                w_rj_we = 1'b1;
                w_addr  = r_cnt;
                w_wl    = bus.word_l;
                w_wr    = bus.word_r;
            end
            LOAD_COEF: if (bus.word_valid) begin
                w_coef_we = 1'b1;
                w_addr    = r_cnt;
                w_wl      = bus.word_l;
                w_wr      = bus.word_r;
            end
            RUN, SLEEP: if (bus.word_valid && (r_state == RUN || !w_zero)) begin
                w_data_we = 1'b1;
                w_sample  = 1'b1;
                w_addr    = AW'(r_head);
                w_wl      = bus.word_l;
                w_wr      = bus.word_r;
            end
            default: ;
        endcase
        if (bus.Start) begin
            w_rj_we   = 1'b0;
            w_coef_we = 1'b0;
            w_data_we = 1'b0;
            w_sample  = 1'b0;
        end
    end

    // A written sample waits in r_pend until the ALU is idle
    assign w_issue = w_active && r_pend && !r_alu_busy && !bus.Start;

    always_ff @(posedge SCLK or negedge Reset_n) begin
        if (!Reset_n || bus.Start) begin
            r_clr_cnt   <= '0;
            r_cnt       <= '0;
            r_head      <= '0;
            r_zero_cnt  <= '0;
            r_pend      <= 1'b0;
            r_pend_addr <= '0;
            r_alu_busy  <= 1'b0;
            r_overrun   <= 1'b0;
            r_inready   <= 1'b0;
            r_sleep     <= 1'b0;
            r_alu_start <= 1'b0;
            r_x_head    <= '0;
            r_rj_we     <= 1'b0;
            r_coef_we   <= 1'b0;
            r_data_we   <= 1'b0;
            r_wr_addr   <= '0;
            r_wdata_l   <= '0;
            r_wdata_r   <= '0;
        end else begin
            r_rj_we   <= w_rj_we;
            r_coef_we <= w_coef_we;
            r_data_we <= w_data_we;
            r_wr_addr <= w_addr;
            r_wdata_l <= w_wl;
            r_wdata_r <= w_wr;
            r_inready <= (r_state == LOAD_RJ) || (r_state == LOAD_COEF) || w_active;
            r_sleep   <= (w_next == SLEEP);
            if (r_state == INIT || r_state == CLEAR) r_clr_cnt <= r_clr_cnt + DW'(1);
            if (w_rj_we)   r_cnt <= (r_cnt == RJ_LAST)   ? '0 : r_cnt + AW'(1);
            if (w_coef_we) r_cnt <= (r_cnt == COEF_LAST) ? '0 : r_cnt + AW'(1);
            if (w_sample) begin
                r_head      <= r_head + DW'(1);
                r_zero_cnt  <= w_zero ? w_zc_inc : '0;
                r_pend      <= 1'b1;
                r_pend_addr <= r_head;
                // ALU already committed to an earlier sample
                if (r_alu_busy || r_pend) r_overrun <= 1'b1;
            end else if (w_issue) begin
                r_pend <= 1'b0;
            end
            r_alu_start <= w_issue;
            if (w_issue) r_x_head <= AW'(r_pend_addr);
            if (w_issue)                        r_alu_busy <= 1'b1;
            else if (w_active && bus.alu_done)  r_alu_busy <= 1'b0;
        end
    end

    // Load flags survive Reset_n so a reset only reloads what is missing
    always_ff @(posedge SCLK) begin
        if (Reset_n && bus.Start) begin
            r_rj_loaded   <= 1'b0;
            r_coef_loaded <= 1'b0;
        end else begin
            if (w_rj_we && r_cnt == RJ_LAST)     r_rj_loaded   <= 1'b1;
            if (w_coef_we && r_cnt == COEF_LAST) r_coef_loaded <= 1'b1;
        end
    end

    assign bus.InReady   = r_inready;
    assign bus.rj_we     = r_rj_we;
    assign bus.coef_we   = r_coef_we;
    assign bus.data_we   = r_data_we;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wdata_l   = r_wdata_l;
    assign bus.wdata_r   = r_wdata_r;
    assign bus.alu_start = r_alu_start;
    assign bus.x_head    = r_x_head;
    assign bus.sleep     = r_sleep;
    assign bus.overrun   = r_overrun;
endmodule

// File: tb/tb_msdap_ctrl.sv
// Directed bench for msdap_ctrl: init/clear, Rj and coefficient load, run,
// wrap, sleep/wake, async reset in RUN and LOAD_COEF, overrun and Start.
module tb_msdap_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    msdap_ctrl_if #(.AW(9)) bus();

    msdap_ctrl #(
        .NUM_RJ(16), .NUM_COEF(512), .DATA_DEPTH(256), .SLEEP_COUNT(800), .AW(9)
    ) dut (
        .SCLK(clk),
        .Reset_n(rst_n),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    int alu_lat = 3;

    // ALU model: alu_done pulses alu_lat cycles after each alu_start
    initial begin
        int cd;
        cd = 0;
        bus.alu_done = 1'b0;
        forever begin
            @(negedge clk);
            bus.alu_done = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) bus.alu_done = 1'b1;
            end
            if (bus.alu_start) cd = alu_lat;
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time exceeded, got timeout want finish");
        $fatal(1);
    end

    task automatic send_word(input logic [15:0] l, input logic [15:0] r);
        bus.word_valid = 1'b1;
        bus.word_l = l;
        bus.word_r = r;
        @(negedge clk);
        bus.word_valid = 1'b0;
        bus.word_l = '0;
        bus.word_r = '0;
    endtask

    task automatic send_sample(input logic [15:0] l, input logic [15:0] r,
                               output logic we, output logic [8:0] addr,
                               output logic [15:0] dl, output logic [15:0] dr,
                               output logic slp, output logic st, output logic [8:0] xh);
        send_word(l, r);
        we = bus.data_we; addr = bus.wr_addr; dl = bus.wdata_l; dr = bus.wdata_r;
        slp = bus.sleep;
        @(negedge clk);
        st = bus.alu_start; xh = bus.x_head;
        repeat (5) @(negedge clk);
    endtask

    task automatic clear_phase(output int nclr, output int bad, output int nload,
                               output logic ready);
        nclr = 0; bad = 0; nload = 0; ready = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (bus.rj_we || bus.coef_we) nload++;
            if (bus.data_we) begin
                if (bus.wr_addr != 9'(nclr) || bus.wdata_l != 0 || bus.wdata_r != 0) bad++;
                nclr++;
            end
            if (bus.InReady) begin
                ready = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic load_rj(output int bad);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            send_word(16'(i + 1), 16'(16'h0100 + i));
            if (!(bus.rj_we && !bus.coef_we && !bus.data_we && bus.wr_addr == 9'(i) &&
                  bus.wdata_l == 16'(i + 1) && bus.wdata_r == 16'(16'h0100 + i))) bad++;
            @(negedge clk);
        end
    endtask

    task automatic load_coef(input int n, output int bad);
        bad = 0;
        for (int i = 0; i < n; i++) begin
            send_word(16'(i), 16'(i) ^ 16'hFFFF);
            if (!(bus.coef_we && !bus.rj_we && !bus.data_we && bus.wr_addr == 9'(i) &&
                  bus.wdata_l == 16'(i) && bus.wdata_r == (16'(i) ^ 16'hFFFF))) bad++;
            @(negedge clk);
        end
    endtask

    function automatic logic [56:0] out_vec();
        return {bus.InReady, bus.rj_we, bus.coef_we, bus.data_we, bus.alu_start,
                bus.sleep, bus.overrun, bus.wr_addr, bus.wdata_l, bus.wdata_r, bus.x_head};
    endfunction

    task automatic test_reset();
        logic [56:0] v;
        bus.Start = 1'b0; bus.word_valid = 1'b0; bus.word_l = '0; bus.word_r = '0;
        rst_n = 1'b0;
        #3;
        v = out_vec();
        checks++;
        if (v !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", v); end
        #20 rst_n = 1'b1;
        @(negedge clk);
        bus.Start = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.InReady !== 1'b0 || bus.data_we !== 1'b0) begin
            errors++;
            $display("FAIL start_idle: got InReady=%b data_we=%b want 0 0", bus.InReady, bus.data_we);
        end
        bus.Start = 1'b0;
    endtask

    task automatic test_init_load();
        int nclr, bad, nload;
        logic ready;
        clear_phase(nclr, bad, nload, ready);
        checks++;
        if (!ready || nclr != 256 || bad != 0) begin
            errors++;
            $display("FAIL init_clear: got ready=%b writes=%0d bad=%0d want 1 256 0", ready, nclr, bad);
        end
        load_rj(bad);
        checks++;
        if (bad != 0) begin errors++; $display("FAIL rj_load: got bad=%0d want 0", bad); end
        load_coef(512, bad);
        checks++;
        if (bad != 0) begin errors++; $display("FAIL coef_load: got bad=%0d want 0", bad); end
        checks++;
        if (bus.InReady !== 1'b1) begin errors++; $display("FAIL run_inready: got %b want 1", bus.InReady); end
    endtask

    task automatic test_run_basic();
        logic we, slp, st;
        logic [8:0] addr, xh;
        logic [15:0] dl, dr;
        int bad;
        send_sample(16'h1234, 16'hABCD, we, addr, dl, dr, slp, st, xh);
        checks++;
        if (!(we && addr == 9'd0 && dl == 16'h1234 && dr == 16'hABCD)) begin
            errors++;
            $display("FAIL run_write: got we=%b addr=%0d data=%h/%h want 1 0 1234/abcd", we, addr, dl, dr);
        end
        checks++;
        if (!(st && xh == 9'd0)) begin
            errors++; $display("FAIL run_start: got start=%b x_head=%0d want 1 0", st, xh);
        end
        bad = 0;
        for (int i = 1; i < 256; i++) begin
            send_sample(16'(i), 16'h8000, we, addr, dl, dr, slp, st, xh);
            if (!(we && addr == 9'(i) && st && xh == 9'(i))) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL run_seq: got bad=%0d want 0", bad); end
        send_sample(16'h0101, 16'h0202, we, addr, dl, dr, slp, st, xh);
        checks++;
        if (!(we && addr == 9'd0 && st && xh == 9'd0)) begin
            errors++; $display("FAIL run_wrap: got addr=%0d x_head=%0d want 0 0", addr, xh);
        end
    endtask

    task automatic test_sleep();
        logic we, slp, st, slp_prev;
        logic [8:0] addr, xh;
        logic [15:0] dl, dr;
        int nst, nwe;
        nst = 0; slp_prev = 1'b0; slp = 1'b0;
        for (int i = 0; i < 800; i++) begin
            slp_prev = slp;
            send_sample(16'h0, 16'h0, we, addr, dl, dr, slp, st, xh);
            if (st) nst++;
        end
        checks++;
        if (nst != 800) begin errors++; $display("FAIL zero_starts: got %0d want 800", nst); end
        checks++;
        if (!(slp === 1'b1 && slp_prev === 1'b0)) begin
            errors++; $display("FAIL sleep_enter: got prev=%b last=%b want 0 1", slp_prev, slp);
        end
        nst = 0; nwe = 0;
        for (int i = 0; i < 5; i++) begin
            send_sample(16'h0, 16'h0, we, addr, dl, dr, slp, st, xh);
            if (we) nwe++;
            if (st) nst++;
        end
        checks++;
        if (nwe != 0 || nst != 0 || bus.sleep !== 1'b1) begin
            errors++;
            $display("FAIL sleep_discard: got we=%0d start=%0d sleep=%b want 0 0 1", nwe, nst, bus.sleep);
        end
        send_sample(16'h0007, 16'h0000, we, addr, dl, dr, slp, st, xh);
        checks++;
        if (!(we && addr == 9'd33 && dl == 16'h0007 && !slp && st && xh == 9'd33)) begin
            errors++;
            $display("FAIL wake: got we=%b addr=%0d sleep=%b start=%b x_head=%0d want 1 33 0 1 33",
                     we, addr, slp, st, xh);
        end
    endtask

    task automatic test_reset_run();
        logic [56:0] v;
        int nclr, bad, nload;
        logic ready, we, slp, st;
        logic [8:0] addr, xh;
        logic [15:0] dl, dr;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 v = out_vec();
        checks++;
        if (v !== '0) begin errors++; $display("FAIL rst_run_outputs: got %h want 0", v); end
        #9 rst_n = 1'b1;
        @(negedge clk);
        clear_phase(nclr, bad, nload, ready);
        checks++;
        if (!ready || nclr != 256 || bad != 0 || nload != 0) begin
            errors++;
            $display("FAIL rst_run_clear: got ready=%b writes=%0d bad=%0d loads=%0d want 1 256 0 0",
                     ready, nclr, bad, nload);
        end
        send_sample(16'h0055, 16'h0000, we, addr, dl, dr, slp, st, xh);
        checks++;
        if (!(we && addr == 9'd0 && !bus.rj_we && st && xh == 9'd0)) begin
            errors++; $display("FAIL rst_run_sample: got we=%b addr=%0d start=%b want 1 0 1", we, addr, st);
        end
    endtask

    task automatic test_overrun();
        int n;
        logic found;
        alu_lat = 8;
        send_word(16'h00AA, 16'h0001);
        @(negedge clk);
        checks++;
        if (!(bus.alu_start && bus.x_head == 9'd1)) begin
            errors++; $display("FAIL ovr_first: got start=%b x_head=%0d want 1 1", bus.alu_start, bus.x_head);
        end
        send_word(16'h00BB, 16'h0002);
        checks++;
        if (!(bus.data_we && bus.wr_addr == 9'd2 && bus.overrun)) begin
            errors++;
            $display("FAIL ovr_flag: got we=%b addr=%0d overrun=%b want 1 2 1", bus.data_we, bus.wr_addr, bus.overrun);
        end
        n = 0; found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n++;
            if (bus.alu_start) begin found = 1'b1; break; end
        end
        checks++;
        if (!(found && n == 9 && bus.x_head == 9'd2)) begin
            errors++;
            $display("FAIL ovr_deferred: got found=%b cycles=%0d x_head=%0d want 1 9 2", found, n, bus.x_head);
        end
        alu_lat = 3;
        repeat (25) @(negedge clk);
        checks++;
        if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", bus.overrun); end
    endtask

    task automatic test_start_mid_run();
        int nclr, bad, nload;
        logic ready;
        bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        checks++;
        if (bus.overrun !== 1'b0 || bus.InReady !== 1'b0) begin
            errors++;
            $display("FAIL start_run: got overrun=%b InReady=%b want 0 0", bus.overrun, bus.InReady);
        end
        clear_phase(nclr, bad, nload, ready);
        checks++;
        if (!ready || nclr != 256 || bad != 0) begin
            errors++;
            $display("FAIL start_clear: got ready=%b writes=%0d bad=%0d want 1 256 0", ready, nclr, bad);
        end
    endtask

    task automatic test_reset_coef();
        int nclr, bad, nload;
        logic ready, we, slp, st;
        logic [8:0] addr, xh;
        logic [15:0] dl, dr;
        load_rj(bad);
        checks++;
        if (bad != 0) begin errors++; $display("FAIL reload_rj: got bad=%0d want 0", bad); end
        load_coef(100, bad);
        checks++;
        if (bad != 0) begin errors++; $display("FAIL part_coef: got bad=%0d want 0", bad); end
        #2 rst_n = 1'b0;
        #10 rst_n = 1'b1;
        @(negedge clk);
        clear_phase(nclr, bad, nload, ready);
        checks++;
        if (!ready || nclr != 256 || bad != 0 || nload != 0) begin
            errors++;
            $display("FAIL coef_rst_clear: got ready=%b writes=%0d bad=%0d loads=%0d want 1 256 0 0",
                     ready, nclr, bad, nload);
        end
        load_coef(512, bad);
        checks++;
        if (bad != 0) begin errors++; $display("FAIL coef_restart: got bad=%0d want 0", bad); end
        send_sample(16'h4321, 16'h0001, we, addr, dl, dr, slp, st, xh);
        checks++;
        if (!(we && addr == 9'd0 && dl == 16'h4321 && st && xh == 9'd0)) begin
            errors++; $display("FAIL coef_rst_run: got we=%b addr=%0d start=%b want 1 0 1", we, addr, st);
        end
    endtask

    initial begin
        test_reset();
        test_init_load();
        test_run_basic();
        test_sleep();
        test_reset_run();
        test_overrun();
        test_start_mid_run();
        test_reset_coef();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
